add_serial: RTL and testbench

Bit-serial unsigned adder for the 4-bit ALU. It is the additive counterpart of the ALU's absolute-difference subtractor and uses the same operand widths and 8-bit zero-extended result format. Operands are captured on a start strobe and added LSB-first, one bit per clock, through a single full-adder cell. The result is presented with a one-cycle done pulse, so a subtract/add round trip can be checked end to end.

---
 rtl/add_serial_pkg.sv | 21 ++
 rtl/add_serial_if.sv | 27 ++
 rtl/full_adder_1b.sv | 15 +
 rtl/add_serial.sv | 104 ++++++++++
 tb/tb_add_serial.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/add_serial_pkg.sv
// rtl/add_serial_pkg.sv - shared types and sizing for the bit-serial adder
// Purpose: FSM state enum, default operand width and bit-counter sizing.
// Ports: none (package).
package add_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 4;

  // Bit counter must index WIDTH positions; a 1-bit adder still needs a 1-bit counter.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  localparam int CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/add_serial_if.sv
// rtl/add_serial_if.sv - request/result bundle for the bit-serial adder
// Purpose: groups the start strobe, operands and result signals.
// Ports: start, A, B (requester -> adder); busy, done, sum (adder -> requester).
interface add_serial_if
  import add_serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic               start;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] sum;

  modport master (
    output start, A, B,
    input  busy, done, sum
  );

  modport slave (
    input  start, A, B,
    output busy, done, sum
  );

endinterface

// File: rtl/full_adder_1b.sv
// rtl/full_adder_1b.sv - single-bit combinational full adder
// Purpose: the one adder cell the serial datapath reuses every cycle.
// Ports: a, b, cin (inputs); s = a^b^cin, cout = majority(a,b,cin) (outputs).
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/add_serial.sv
// rtl/add_serial.sv - LSB-first bit-serial unsigned adder with done pulse
// Purpose: captures A/B on an accepted start, adds one bit per clock, then
//   presents the zero-extended sum with a one-cycle done pulse.
// Ports: clk, rst (sync, active-high); bus (slave): start, A, B in;
//   busy, done, sum out (all outputs registered).
module add_serial
  import add_serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  add_serial_if.slave  bus
);

  localparam int CW = cnt_width(WIDTH);

  state_e               state_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [WIDTH-1:0]     part_q;
  logic                 carry_q;
  logic [CW-1:0]        cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   sum_q;

  logic                 fa_s;
  logic                 fa_c;
  logic [WIDTH-1:0]     part_d;
  logic [2*WIDTH-1:0]   sum_d;

  full_adder_1b u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  // Partial result with this cycle's sum bit placed at the counter position;
  // sum_d is what gets published on the last ADD cycle (carry-out at bit WIDTH).
  always_comb begin
    part_d        = part_q;
    part_d[cnt_q] = fa_s;
    sum_d         = '0;
    sum_d[WIDTH:0] = {fa_c, part_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            part_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ADD;
          end else begin
            state_q <= IDLE;
          end
        end
        ADD: begin
          // start is deliberately not looked at here: requests during ADD are dropped.
          carry_q <= fa_c;
          part_q  <= part_d;
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            sum_q   <= sum_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;

endmodule

// File: tb/tb_add_serial.sv
// tb/tb_add_serial.sv - self-checking bench for the bit-serial adder
module tb_add_serial;
  localparam int W = 4;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   cyc;
  bit   chk_en;

  add_serial_if #(.WIDTH(W)) bus ();

  add_serial #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: a request is taken whenever no addition is running, and
  // the result A+B appears exactly W edges later.
  int         m_rem;
  logic       m_busy;
  logic       m_done;
  logic [7:0] m_sum;
  logic [7:0] m_pend;

  initial begin
    m_rem = 0; m_busy = 0; m_done = 0; m_sum = 0; m_pend = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_rem = 0; m_busy = 0; m_done = 0; m_sum = 0;
    end else begin
      m_done = 0;
      if (m_rem > 0) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_sum  = m_pend;
          m_done = 1;
          m_busy = 0;
        end
      end else if (bus.start) begin
        m_pend = 8'(bus.A) + 8'(bus.B);
        m_rem  = W;
        m_busy = 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", 32'(bus.busy), 32'(m_busy));
      check("model_done", 32'(bus.done), 32'(m_done));
      check("model_sum",  32'(bus.sum),  32'(m_sum));
    end
  end

  // Called at a negedge; start is seen by the next edge, operands scrambled after.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                       output int lat, output int busy_cnt);
    bus.start = 1'b1; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.start = 1'b0; bus.A = 4'($urandom); bus.B = 4'($urandom);
    busy_cnt = bus.busy ? 1 : 0;
    lat = 0;
    wait_done(lat, busy_cnt);
  endtask

  task automatic wait_done(inout int lat, inout int busy_cnt);
    bit seen;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (bus.done) seen = 1;
      else busy_cnt += bus.busy ? 1 : 0;
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  int lat, bc, c1, c2, pulses;
  logic [4:0] expd;

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; chk_en = 0;
    bus.start = 0; bus.A = 0; bus.B = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    chk_en = 1;
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_done", 32'(bus.done), 0);
    check("reset_sum",  32'(bus.sum),  0);
    rst = 0;
    @(negedge clk);

    // basic add
    do_op(4'd9, 4'd5, lat, bc);
    check("basic_latency", lat, 4);
    check("basic_busy_cycles", bc, 4);
    check("basic_sum", 32'(bus.sum), 32'h0E);
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 0);

    // carry out and zero
    do_op(4'd15, 4'd15, lat, bc);
    check("carry_sum", 32'(bus.sum), 32'h1E);
    check("carry_bit4", 32'(bus.sum[4]), 1);
    check("carry_hi_zero", 32'(bus.sum[7:5]), 0);
    do_op(4'd0, 4'd0, lat, bc);
    check("zero_done_latency", lat, 4);
    check("zero_sum", 32'(bus.sum), 0);
    @(negedge clk);

    // start during ADD is ignored
    bus.start = 1; bus.A = 4'd3; bus.B = 4'd4;
    @(negedge clk);
    bus.A = 4'd1; bus.B = 4'd1;
    repeat (2) @(negedge clk);
    bus.start = 0;
    lat = 2; bc = 0;
    wait_done(lat, bc);
    check("ignore_latency", lat, 4);
    check("ignore_sum", 32'(bus.sum), 32'h07);
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      pulses += bus.done ? 1 : 0;
    end
    check("ignore_extra_done", pulses, 0);

    // back-to-back with start held
    bus.start = 1; bus.A = 4'd7; bus.B = 4'd8;
    @(negedge clk);
    bus.A = 4'd2; bus.B = 4'd2;
    lat = 0; bc = 1;
    wait_done(lat, bc);
    c1 = cyc;
    check("b2b_first_sum", 32'(bus.sum), 32'h0F);
    @(negedge clk);
    bus.start = 0; bus.A = 4'd9; bus.B = 4'd9;
    lat = 0; bc = 1;
    wait_done(lat, bc);
    c2 = cyc;
    check("b2b_second_sum", 32'(bus.sum), 32'h04);
    check("b2b_spacing", c2 - c1, 5);
    @(negedge clk);

    // reset during the second ADD cycle
    bus.start = 1; bus.A = 4'd5; bus.B = 4'd5;
    @(negedge clk);
    bus.start = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("midrst_busy", 32'(bus.busy), 0);
    check("midrst_done", 32'(bus.done), 0);
    check("midrst_sum",  32'(bus.sum),  0);
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      pulses += bus.done ? 1 : 0;
    end
    check("midrst_no_done", pulses, 0);
    do_op(4'd6, 4'd3, lat, bc);
    check("after_rst_sum", 32'(bus.sum), 32'h09);
    @(negedge clk);

    // exhaustive cross-check, including the subtractor round trip
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_op(4'(a), 4'(b), lat, bc);
        check("exh_sum", 32'(bus.sum), 32'(a + b));
        expd = (bus.sum[3:0] >= 4'(b)) ? 5'(bus.sum[3:0] - 4'(b)) : 5'(4'(b) - bus.sum[3:0]);
        check("exh_sub_roundtrip", 32'(expd), 32'((a + b > 15) ? 16 - a : a));
      end
    end

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
